// File: rtl/rx_data_buffer_pkg.sv
// ----------------------------------------------------------------------------
// rx_data_buffer_pkg
//   Shared definitions for the rx byte-to-word buffer:
//   - BYTES_PER_WORD : lanes per output word
//   - pack_state_e   : packer state (IDLE / COLLECT)
//   - fifo_word_t    : one buffered entry {last, keep, data}
//   - keep_for_count : byte count -> contiguous keep mask
//   - sat_inc16      : saturating 16-bit increment
// ----------------------------------------------------------------------------
package rx_data_buffer_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 8 * BYTES_PER_WORD;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } pack_state_e;

   typedef struct packed {
      logic                      last;
      logic [BYTES_PER_WORD-1:0] keep;
      logic [WORD_W-1:0]         data;
   } fifo_word_t;

   localparam int FIFO_WIDTH = $bits(fifo_word_t);

   // k valid bytes occupy lanes 0..k-1
   function automatic logic [BYTES_PER_WORD-1:0] keep_for_count(input logic [2:0] k);
      logic [BYTES_PER_WORD-1:0] m;
      case (k)
         3'd1:    m = 4'h1;
         3'd2:    m = 4'h3;
         3'd3:    m = 4'h7;
         default: m = 4'hF;
      endcase
      return m;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

endpackage

// File: rtl/rx_data_buffer_if.sv
// ----------------------------------------------------------------------------
// rx_data_buffer_if
//   Byte-side input (from the rx controller) and word-side stream output.
//   slave  : the buffer's view (consumes bytes, produces words)
//   master : the environment's view (offers bytes, accepts words)
// ----------------------------------------------------------------------------
interface rx_data_buffer_if;
   import rx_data_buffer_pkg::*;

   logic                      brx_valid;
   logic [7:0]                brx_data;
   logic                      brx_last;
   logic                      brx_full;
   logic [WORD_W-1:0]         m_tdata;
   logic [BYTES_PER_WORD-1:0] m_tkeep;
   logic                      m_tlast;
   logic                      m_tvalid;
   logic                      m_tready;

   modport slave (
      input  brx_valid, brx_data, brx_last, m_tready,
      output brx_full, m_tdata, m_tkeep, m_tlast, m_tvalid
   );

   modport master (
      output brx_valid, brx_data, brx_last, m_tready,
      input  brx_full, m_tdata, m_tkeep, m_tlast, m_tvalid
   );

endinterface

// File: rtl/rx_data_buffer_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. pop_data always shows the head
//   entry; a push while full or a pop while empty is ignored.
//   Ports: clk, rst_n (sync, active-low), push/push_data, pop/pop_data,
//          full, empty, count (occupancy 0..DEPTH).
//   DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full     = (count_q == DEPTH_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem[rd_ptr_q];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/rx_data_buffer.sv
// ----------------------------------------------------------------------------
// rx_data_buffer
//   Packs bytes from the rx controller into little-endian 32-bit words and
//   buffers them in a FWFT FIFO for a ready/valid stream consumer.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     bus (slave)       brx_valid/brx_data/brx_last in, brx_full out;
//                       m_tdata/m_tkeep/m_tlast/m_tvalid out, m_tready in
//     frame_len         byte count of the last completed input frame
//     frame_len_valid   one-cycle pulse when frame_len updates
//     frame_count       frames whose last word has been read out (wraps)
// ----------------------------------------------------------------------------
module rx_data_buffer
   import rx_data_buffer_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rx_data_buffer_if.slave      bus,
   output logic [15:0]          frame_len,
   output logic                 frame_len_valid,
   output logic [15:0]          frame_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [CW-1:0]   fifo_count;
   fifo_word_t      push_word, head_word;

   pack_state_e     state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic [15:0]     len_cnt_q, len_cnt_d;
   logic [15:0]     frame_len_q, frame_len_d;
   logic            flv_q, flv_d;
   logic [15:0]     frame_count_q, frame_count_d;

   logic              accept, complete;
   logic [WORD_W-1:0] merged;
   logic [BYTES_PER_WORD-1:0] keep;

   sync_fifo #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (push_word),
      .pop       (fifo_pop),
      .pop_data  (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // brx_full comes straight from the FIFO's occupancy register, so the
   // rx controller never sees a combinational path through this block.
   assign bus.brx_full = fifo_full;
   assign bus.m_tvalid = ~fifo_empty;
   assign bus.m_tdata  = head_word.data;
   assign bus.m_tkeep  = head_word.keep;
   assign bus.m_tlast  = head_word.last;

   assign frame_len       = frame_len_q;
   assign frame_len_valid = flv_q;
   assign frame_count     = frame_count_q;

   // Packer: merge the incoming byte into its lane and decide on a push.
   always_comb begin
      accept   = bus.brx_valid & ~fifo_full;
      complete = accept & (bus.brx_last | (idx_q == 2'(BYTES_PER_WORD - 1)));

      merged = data_q;
      merged[{idx_q, 3'b000} +: 8] = bus.brx_data;

      // Lanes above the current byte may hold stale bytes from an earlier
      // word (data_q is never cleared), so they are masked at push time.
      keep      = keep_for_count({1'b0, idx_q} + 3'd1);
      push_word = '0;
      push_word.keep = keep;
      push_word.last = bus.brx_last;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         push_word.data[i*8 +: 8] = keep[i] ? merged[i*8 +: 8] : 8'h00;
      end
      fifo_push = complete;

      data_d = accept ? merged : data_q;

      idx_d = idx_q;
      if (complete)    idx_d = 2'd0;
      else if (accept) idx_d = idx_q + 2'd1;

      state_d = state_q;
      case (state_q)
         IDLE:    if (accept & ~bus.brx_last) state_d = COLLECT;
         COLLECT: if (accept &  bus.brx_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Frame length and read-side frame counter.
   always_comb begin
      len_cnt_d     = len_cnt_q;
      frame_len_d   = frame_len_q;
      flv_d         = 1'b0;
      fifo_pop      = bus.m_tready & ~fifo_empty;
      frame_count_d = frame_count_q;

      if (accept) begin
         if (bus.brx_last) begin
            frame_len_d = sat_inc16(len_cnt_q);
            len_cnt_d   = 16'd0;
            flv_d       = 1'b1;
         end else begin
            len_cnt_d   = sat_inc16(len_cnt_q);
         end
      end

      if (fifo_pop && head_word.last) frame_count_d = frame_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= 2'd0;
         len_cnt_q     <= 16'd0;
         frame_len_q   <= 16'd0;
         flv_q         <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         len_cnt_q     <= len_cnt_d;
         frame_len_q   <= frame_len_d;
         flv_q         <= flv_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Partial-word bytes; validity is tracked by idx_q alone.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_rx_data_buffer.sv
module tb_rx_data_buffer;
   import rx_data_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] frame_len;
   logic        frame_len_valid;
   logic [15:0] frame_count;

   int tests  = 0;
   int failed = 0;

   rx_data_buffer_if bus();

   rx_data_buffer #(.DEPTH(16)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .frame_len       (frame_len),
      .frame_len_valid (frame_len_valid),
      .frame_count     (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        rdy;
      logic        e_tv;
      logic [31:0] e_data;
      logic [3:0]  e_keep;
      logic        e_last;
      logic        e_flv;
      logic [15:0] e_len;
      logic [15:0] e_fc;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   vec_t  tbl[$];
   word_t exp_q[$];

   function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic rdy,
                               logic tv, logic [31:0] data, logic [3:0] keep,
                               logic last, logic flv, logic [15:0] len,
                               logic [15:0] fc);
      vec_t r;
      r.v = v; r.d = d; r.l = l; r.rdy = rdy;
      r.e_tv = tv; r.e_data = data; r.e_keep = keep; r.e_last = last;
      r.e_flv = flv; r.e_len = len; r.e_fc = fc;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      bus.brx_valid = 1'b0;
      bus.brx_last  = 1'b0;
      bus.brx_data  = 8'h00;
      bus.m_tready  = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " brx_full"}, {31'd0, bus.brx_full}, 32'd0);
      chk({tag, " m_tvalid"}, {31'd0, bus.m_tvalid}, 32'd0);
      chk({tag, " frame_len"}, {16'd0, frame_len}, 32'd0);
      chk({tag, " frame_len_valid"}, {31'd0, frame_len_valid}, 32'd0);
      chk({tag, " frame_count"}, {16'd0, frame_count}, 32'd0);
   endtask

   // Fill with 64 bytes (16 words, no last) while the consumer stalls.
   task automatic fill64(input string tag, input logic [7:0] base);
      bus.m_tready = 1'b0;
      bus.brx_last = 1'b0;
      for (int i = 0; i < 64; i++) begin
         bus.brx_valid = 1'b1;
         bus.brx_data  = 8'(base + i);
         step();
         chk($sformatf("%s full after byte %0d", tag, i), {31'd0, bus.brx_full},
             {31'd0, (i == 63)});
      end
      for (int w = 0; w < 16; w++) begin
         word_t e;
         e.d = {8'(base + 4*w + 3), 8'(base + 4*w + 2), 8'(base + 4*w + 1), 8'(base + 4*w)};
         e.k = 4'hF;
         e.l = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      bus.brx_valid = 1'b0;
      bus.m_tready  = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
         if (bus.m_tvalid) begin
            chk($sformatf("%s word%0d data", tag, n), bus.m_tdata, exp_q[0].d);
            chk($sformatf("%s word%0d keep", tag, n), {28'd0, bus.m_tkeep}, {28'd0, exp_q[0].k});
            chk($sformatf("%s word%0d last", tag, n), {31'd0, bus.m_tlast}, {31'd0, exp_q[0].l});
            void'(exp_q.pop_front());
            n++;
         end
         step();
      end
      if (exp_q.size() > 0) begin
         tests++;
         failed++;
         $display("FAIL %s drain timeout: %0d words missing, expected 0", tag, exp_q.size());
         exp_q.delete();
      end
      bus.m_tready = 1'b0;
      chk({tag, " empty after drain"}, {31'd0, bus.m_tvalid}, 32'd0);
   endtask

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      chk_zero("reset");

      // ---------------- table-driven frames ----------------
      //            v  d      l  rdy tv data          keep  last flv len    fc
      tbl.push_back(mk(1, 8'h01, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd0, 16'd0));
      tbl.push_back(mk(1, 8'h02, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd0, 16'd0));
      tbl.push_back(mk(1, 8'h03, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd0, 16'd0));
      tbl.push_back(mk(1, 8'h04, 0, 1, 1, 32'h04030201, 4'hF, 0, 0, 16'd0, 16'd0));
      tbl.push_back(mk(1, 8'h05, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd0, 16'd0));
      tbl.push_back(mk(1, 8'h06, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd0, 16'd0));
      tbl.push_back(mk(1, 8'h07, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd0, 16'd0));
      tbl.push_back(mk(1, 8'h08, 1, 1, 1, 32'h08070605, 4'hF, 1, 1, 16'd8, 16'd0));
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd8, 16'd1));
      tbl.push_back(mk(1, 8'hA0, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd8, 16'd1));
      tbl.push_back(mk(1, 8'hA1, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd8, 16'd1));
      tbl.push_back(mk(1, 8'hA2, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd8, 16'd1));
      tbl.push_back(mk(1, 8'hA3, 0, 1, 1, 32'hA3A2A1A0, 4'hF, 0, 0, 16'd8, 16'd1));
      tbl.push_back(mk(1, 8'hA4, 1, 1, 1, 32'h000000A4, 4'h1, 1, 1, 16'd5, 16'd1));
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd5, 16'd2));
      tbl.push_back(mk(1, 8'h5A, 1, 0, 1, 32'h0000005A, 4'h1, 1, 1, 16'd1, 16'd2));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 32'h0000005A, 4'h1, 1, 0, 16'd1, 16'd2));
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        4'h0, 0, 0, 16'd1, 16'd3));

      for (int i = 0; i < tbl.size(); i++) begin
         bus.brx_valid = tbl[i].v;
         bus.brx_data  = tbl[i].d;
         bus.brx_last  = tbl[i].l;
         bus.m_tready  = tbl[i].rdy;
         step();
         chk($sformatf("vec%0d m_tvalid", i), {31'd0, bus.m_tvalid}, {31'd0, tbl[i].e_tv});
         if (tbl[i].e_tv) begin
            chk($sformatf("vec%0d m_tdata", i), bus.m_tdata, tbl[i].e_data);
            chk($sformatf("vec%0d m_tkeep", i), {28'd0, bus.m_tkeep}, {28'd0, tbl[i].e_keep});
            chk($sformatf("vec%0d m_tlast", i), {31'd0, bus.m_tlast}, {31'd0, tbl[i].e_last});
         end
         chk($sformatf("vec%0d brx_full", i), {31'd0, bus.brx_full}, 32'd0);
         chk($sformatf("vec%0d frame_len_valid", i), {31'd0, frame_len_valid}, {31'd0, tbl[i].e_flv});
         chk($sformatf("vec%0d frame_len", i), {16'd0, frame_len}, {16'd0, tbl[i].e_len});
         chk($sformatf("vec%0d frame_count", i), {16'd0, frame_count}, {16'd0, tbl[i].e_fc});
      end

      // ---------------- backpressure: overfill then drain ----------------
      do_reset();
      fill64("bp", 8'h00);
      bus.brx_valid = 1'b1;
      for (int i = 64; i < 72; i++) begin
         bus.brx_data = 8'(i);
         step();
         chk($sformatf("bp full while ignored %0d", i), {31'd0, bus.brx_full}, 32'd1);
      end
      drain("bp");

      // ---------------- full FIFO, pop and completing byte together --------
      fill64("sim", 8'h80);
      bus.brx_valid = 1'b1;
      bus.brx_data  = 8'hEE;
      bus.brx_last  = 1'b1;
      bus.m_tready  = 1'b1;
      step();
      chk("sim full after pop", {31'd0, bus.brx_full}, 32'd0);
      chk("sim head after pop", bus.m_tdata, 32'h87868584);
      chk("sim no flv when ignored", {31'd0, frame_len_valid}, 32'd0);
      bus.m_tready = 1'b0;
      step();
      chk("sim full after accept", {31'd0, bus.brx_full}, 32'd1);
      chk("sim flv after accept", {31'd0, frame_len_valid}, 32'd1);
      chk("sim frame_len", {16'd0, frame_len}, 32'd129);
      bus.brx_valid = 1'b0;
      bus.brx_last  = 1'b0;
      void'(exp_q.pop_front());
      begin
         word_t e;
         e.d = 32'h000000EE;
         e.k = 4'h1;
         e.l = 1'b1;
         exp_q.push_back(e);
      end
      drain("sim");
      chk("sim frame_count", {16'd0, frame_count}, 32'd1);

      // ---------------- reset in the middle of a frame ----------------
      bus.m_tready = 1'b0;
      bus.brx_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.brx_valid = 1'b1;
         bus.brx_data  = 8'(8'hC0 + i);
         step();
      end
      do_reset();
      chk_zero("midreset");
      for (int i = 0; i < 4; i++) begin
         bus.brx_valid = 1'b1;
         bus.brx_data  = 8'(8'h11 + i);
         bus.brx_last  = (i == 3);
         step();
      end
      bus.brx_valid = 1'b0;
      bus.brx_last  = 1'b0;
      chk("mid m_tvalid", {31'd0, bus.m_tvalid}, 32'd1);
      chk("mid m_tdata", bus.m_tdata, 32'h14131211);
      chk("mid m_tkeep", {28'd0, bus.m_tkeep}, 32'hF);
      chk("mid m_tlast", {31'd0, bus.m_tlast}, 32'd1);
      chk("mid frame_len", {16'd0, frame_len}, 32'd4);
      bus.m_tready = 1'b1;
      step();
      bus.m_tready = 1'b0;
      chk("mid empty", {31'd0, bus.m_tvalid}, 32'd0);
      chk("mid frame_count", {16'd0, frame_count}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
